// File: rtl/letc_pkg.sv
// Shared types and register map for the LETC machine timer.
package letc_pkg;

  localparam int unsigned TIMER_ADDR_W = 5;
  localparam int unsigned TIMER_DATA_W = 32;

  typedef logic [TIMER_ADDR_W-1:0] timer_addr_t;
  typedef logic [63:0]             timer_word64_t;

  localparam timer_addr_t TIMER_MTIME_LO_ADDR    = 5'h00;
  localparam timer_addr_t TIMER_MTIME_HI_ADDR    = 5'h04;
  localparam timer_addr_t TIMER_MTIMECMP_LO_ADDR = 5'h08;
  localparam timer_addr_t TIMER_MTIMECMP_HI_ADDR = 5'h0C;
  localparam timer_addr_t TIMER_MSIP_ADDR        = 5'h10;

  typedef enum logic {
    TIMER_IDLE = 1'b0,
    TIMER_RESP = 1'b1
  } timer_state_e;

  typedef struct packed {
    logic                    illegal;
    logic [TIMER_DATA_W-1:0] rdata;
  } timer_rsp_t;

  // Byte-lane merge of a write into an existing 32-bit word.
  function automatic logic [TIMER_DATA_W-1:0] timer_merge_bytes(
    input logic [TIMER_DATA_W-1:0] old_word,
    input logic [TIMER_DATA_W-1:0] wdata,
    input logic [3:0]              wstrb
  );
    logic [TIMER_DATA_W-1:0] res;
    res = old_word;
    for (int i = 0; i < 4; i++) begin
      if (wstrb[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/letc_timer_if.sv
// Valid/ready register port between the interconnect bridge (master) and the timer (slave).
interface letc_timer_if;
  import letc_pkg::*;

  logic                    i_req_valid;
  logic                    o_req_ready;
  logic                    i_req_wen;
  timer_addr_t             i_req_addr;
  logic [TIMER_DATA_W-1:0] i_req_wdata;
  logic [3:0]              i_req_wstrb;
  logic                    o_rsp_valid;
  logic                    i_rsp_ready;
  logic [TIMER_DATA_W-1:0] o_rsp_rdata;
  logic                    o_rsp_illegal;

  modport master (
    output i_req_valid, i_req_wen, i_req_addr, i_req_wdata, i_req_wstrb, i_rsp_ready,
    input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_illegal
  );

  modport slave (
    input  i_req_valid, i_req_wen, i_req_addr, i_req_wdata, i_req_wstrb, i_rsp_ready,
    output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_illegal
  );
endinterface

// File: rtl/letc_timer_prescaler.sv
// Divides i_clk into mtime ticks; counts 0..PRESCALE-1 and ticks on the last count.
module letc_timer_prescaler #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  output logic o_tick
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] cnt_q;

  // With PRESCALE=1 the counter never leaves 0, so the tick is constantly high.
  assign o_tick = (cnt_q == LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) cnt_q <= '0;
    else if (o_tick)      cnt_q <= '0;
    else                  cnt_q <= cnt_q + CNT_W'(1);
  end

endmodule

// File: rtl/letc_timer.sv
// RISC-V machine timer (mtime/mtimecmp) with registered timer interrupt.
// Optional msip register at 0x10 when LETC_TIMER_MSIP_EN is defined.
module letc_timer
  import letc_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  letc_timer_if.slave  bus,
  output logic         o_timer_irq_pending,
  output logic         o_software_irq_pending
);

  timer_state_e            state_q, state_d;
  timer_word64_t           mtime_q, mtimecmp_q;
  timer_rsp_t              rsp_q;
  timer_addr_t             word_addr;
  logic                    tick, accept, wr, mtime_wr, legal;
  logic                    sel_mtime_lo, sel_mtime_hi, sel_cmp_lo, sel_cmp_hi, sel_msip;
  logic [TIMER_DATA_W-1:0] rd_word;
  logic                    unused_addr_bits;

  assign unused_addr_bits = ^bus.i_req_addr[1:0];

  letc_timer_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clear (mtime_wr),
    .o_tick  (tick)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= TIMER_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      TIMER_IDLE: if (bus.i_req_valid) state_d = TIMER_RESP;
      TIMER_RESP: if (bus.i_rsp_ready) state_d = TIMER_IDLE;
      default:    state_d = TIMER_IDLE;
    endcase
  end

  always_comb begin
    bus.o_req_ready = 1'b0;
    bus.o_rsp_valid = 1'b0;
    case (state_q)
      TIMER_IDLE: bus.o_req_ready = 1'b1;
      TIMER_RESP: bus.o_rsp_valid = 1'b1;
      default: ;
    endcase
  end

  assign accept   = bus.i_req_valid && (state_q == TIMER_IDLE);
  assign wr       = accept && bus.i_req_wen;
  assign mtime_wr = wr && (sel_mtime_lo || sel_mtime_hi);

  // Address decode and read mux; the two low address bits are ignored.
  always_comb begin
    word_addr    = timer_addr_t'({bus.i_req_addr[4:2], 2'b00});
    sel_mtime_lo = (word_addr == TIMER_MTIME_LO_ADDR);
    sel_mtime_hi = (word_addr == TIMER_MTIME_HI_ADDR);
    sel_cmp_lo   = (word_addr == TIMER_MTIMECMP_LO_ADDR);
    sel_cmp_hi   = (word_addr == TIMER_MTIMECMP_HI_ADDR);
`ifdef LETC_TIMER_MSIP_EN
    sel_msip     = (word_addr == TIMER_MSIP_ADDR);
`else
    sel_msip     = 1'b0;
`endif
    legal   = sel_mtime_lo | sel_mtime_hi | sel_cmp_lo | sel_cmp_hi | sel_msip;
    rd_word = '0;
    if (sel_mtime_lo) rd_word = mtime_q[31:0];
    if (sel_mtime_hi) rd_word = mtime_q[63:32];
    if (sel_cmp_lo)   rd_word = mtimecmp_q[31:0];
    if (sel_cmp_hi)   rd_word = mtimecmp_q[63:32];
`ifdef LETC_TIMER_MSIP_EN
    if (sel_msip)     rd_word = {31'd0, o_software_irq_pending};
`endif
  end

  // A software write beats a coincident tick; the untouched half is held.
  always_ff @(posedge i_clk) begin
    if (i_rst)
      mtime_q <= '0;
    else if (wr && sel_mtime_lo)
      mtime_q[31:0] <= timer_merge_bytes(mtime_q[31:0], bus.i_req_wdata, bus.i_req_wstrb);
    else if (wr && sel_mtime_hi)
      mtime_q[63:32] <= timer_merge_bytes(mtime_q[63:32], bus.i_req_wdata, bus.i_req_wstrb);
    else if (tick)
      mtime_q <= mtime_q + 64'd1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)
      mtimecmp_q <= '1;
    else if (wr && sel_cmp_lo)
      mtimecmp_q[31:0] <= timer_merge_bytes(mtimecmp_q[31:0], bus.i_req_wdata, bus.i_req_wstrb);
    else if (wr && sel_cmp_hi)
      mtimecmp_q[63:32] <= timer_merge_bytes(mtimecmp_q[63:32], bus.i_req_wdata, bus.i_req_wstrb);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) o_timer_irq_pending <= 1'b0;
    else       o_timer_irq_pending <= (mtime_q >= mtimecmp_q);
  end

  // Response is captured at acceptance and held stable until consumed.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rsp_q <= '0;
    end else if (accept) begin
      rsp_q.rdata   <= (bus.i_req_wen || !legal) ? '0 : rd_word;
      rsp_q.illegal <= !legal;
    end
  end

  assign bus.o_rsp_rdata   = rsp_q.rdata;
  assign bus.o_rsp_illegal = rsp_q.illegal;

`ifdef LETC_TIMER_MSIP_EN
  always_ff @(posedge i_clk) begin
    if (i_rst)                                   o_software_irq_pending <= 1'b0;
    else if (wr && sel_msip && bus.i_req_wstrb[0]) o_software_irq_pending <= bus.i_req_wdata[0];
  end
`else
  assign o_software_irq_pending = 1'b0;
`endif

endmodule

// File: tb/tb_letc_timer.sv
// Scoreboard bench for letc_timer: one PRESCALE=4 and one PRESCALE=1 instance on a shared driver.
module tb_letc_timer;
  import letc_pkg::*;

  typedef struct {
    logic [31:0] rdata;
    logic        ill;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        sel;
  logic        req_valid, req_wen, rsp_ready;
  logic [4:0]  req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        irq4, irq1, swirq4, swirq1;

  letc_timer_if bus4 ();
  letc_timer_if bus1 ();

  assign bus4.i_req_valid = req_valid & ~sel;
  assign bus1.i_req_valid = req_valid & sel;
  assign bus4.i_req_wen   = req_wen;   assign bus1.i_req_wen   = req_wen;
  assign bus4.i_req_addr  = req_addr;  assign bus1.i_req_addr  = req_addr;
  assign bus4.i_req_wdata = req_wdata; assign bus1.i_req_wdata = req_wdata;
  assign bus4.i_req_wstrb = req_wstrb; assign bus1.i_req_wstrb = req_wstrb;
  assign bus4.i_rsp_ready = rsp_ready; assign bus1.i_rsp_ready = rsp_ready;

  letc_timer #(.PRESCALE(4)) u_dut4 (
    .i_clk(clk), .i_rst(rst), .bus(bus4),
    .o_timer_irq_pending(irq4), .o_software_irq_pending(swirq4)
  );

  letc_timer #(.PRESCALE(1)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .bus(bus1),
    .o_timer_irq_pending(irq1), .o_software_irq_pending(swirq1)
  );

  logic        m_req_ready, m_rsp_valid, m_rsp_illegal;
  logic [31:0] m_rsp_rdata;
  assign m_req_ready   = sel ? bus1.o_req_ready   : bus4.o_req_ready;
  assign m_rsp_valid   = sel ? bus1.o_rsp_valid   : bus4.o_rsp_valid;
  assign m_rsp_rdata   = sel ? bus1.o_rsp_rdata   : bus4.o_rsp_rdata;
  assign m_rsp_illegal = sel ? bus1.o_rsp_illegal : bus4.o_rsp_illegal;

  int   n_checks = 0;
  int   n_errors = 0;
  int   last_acc = 0;
  exp_t sb_q[$];
  logic irq1_log [256];

  always @(negedge clk) irq1_log[cyc & 255] <= irq1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every consumed response is compared against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && m_rsp_valid && rsp_ready) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_rsp: got rdata %h with nothing expected", m_rsp_rdata);
      end else begin
        e = sb_q.pop_front();
        check({e.name, "_rdata"}, m_rsp_rdata, e.rdata);
        check({e.name, "_illegal"}, 32'(m_rsp_illegal), 32'(e.ill));
      end
    end
  end

  // rel_base >= 0: expected rdata is exp_rdata + (acceptance cycle - rel_base).
  task automatic bus_req(input bit wen, input logic [4:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input logic [31:0] exp_rdata, input bit exp_ill,
                         input int rel_base, input bit wait_rsp, input string name);
    int   n;
    exp_t e;
    @(negedge clk);
    req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wdata; req_wstrb = wstrb;
    n = 0;
    while (!m_req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!m_req_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_accept: req_ready got 0, expected 1", name);
      req_valid = 1'b0;
      return;
    end
    last_acc = cyc + 1;
    e.rdata  = (rel_base >= 0) ? exp_rdata + 32'(last_acc - rel_base) : exp_rdata;
    e.ill    = exp_ill;
    e.name   = name;
    sb_q.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    if (wait_rsp) begin
      n = 0;
      while (sb_q.size() != 0 && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (sb_q.size() != 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL %s_rsp_timeout: got no response, expected one", name);
        sb_q.delete();
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int  r0, a, w, b, a0;
    bit  msip_ill;
    logic [31:0] msip_exp;
`ifdef LETC_TIMER_MSIP_EN
    msip_ill = 1'b0; msip_exp = 32'd1;
`else
    msip_ill = 1'b1; msip_exp = 32'd0;
`endif
    rst = 1'b1; sel = 1'b0; req_valid = 1'b0; req_wen = 1'b0;
    req_addr = '0; req_wdata = '0; req_wstrb = '0; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);

    check("rst_req_ready4", 32'(bus4.o_req_ready), 32'd1);
    check("rst_req_ready1", 32'(bus1.o_req_ready), 32'd1);
    check("rst_rsp_valid4", 32'(bus4.o_rsp_valid), 32'd0);
    check("rst_rsp_rdata1", bus1.o_rsp_rdata, 32'd0);
    check("rst_rsp_ill1",   32'(bus1.o_rsp_illegal), 32'd0);
    check("rst_irq4",       32'(irq4), 32'd0);
    check("rst_irq1",       32'(irq1), 32'd0);
    check("rst_swirq",      32'({swirq4, swirq1}), 32'd0);

    // PRESCALE=4: 40 idle cycles give 10 ticks.
    r0 = cyc;
    rst = 1'b0;
    while (cyc < r0 + 40) @(negedge clk);
    bus_req(1'b0, TIMER_MTIME_LO_ADDR, '0, '0, 32'd10, 1'b0, -1, 1'b1, "p4_mtime_lo");
    bus_req(1'b0, TIMER_MTIME_HI_ADDR, '0, '0, 32'd0, 1'b0, -1, 1'b1, "p4_mtime_hi");
    bus_req(1'b0, TIMER_MTIMECMP_LO_ADDR, '0, '0, 32'hFFFF_FFFF, 1'b0, -1, 1'b1, "p4_cmp_lo_rst");
    check("p4_irq_low", 32'(irq4), 32'd0);

    // PRESCALE=1: irq rise one cycle after mtime reaches mtimecmp.
    sel = 1'b1;
    bus_req(1'b1, TIMER_MTIMECMP_LO_ADDR, 32'd5, 4'hF, 32'd0, 1'b0, -1, 1'b1, "wr_cmp_lo");
    bus_req(1'b1, TIMER_MTIME_HI_ADDR,    32'd0, 4'hF, 32'd0, 1'b0, -1, 1'b1, "wr_mtime_hi0");
    bus_req(1'b1, TIMER_MTIMECMP_HI_ADDR, 32'd0, 4'hF, 32'd0, 1'b0, -1, 1'b1, "wr_cmp_hi0");
    bus_req(1'b1, TIMER_MTIME_LO_ADDR,    32'd0, 4'hF, 32'd0, 1'b0, -1, 1'b1, "wr_mtime_lo0");
    a = last_acc;
    while (cyc < a + 8) @(negedge clk);
    check("irq_before_match", 32'(irq1_log[(a + 5) & 255]), 32'd0);
    check("irq_after_match",  32'(irq1_log[(a + 6) & 255]), 32'd1);

    bus_req(1'b1, TIMER_MTIMECMP_HI_ADDR, 32'd1, 4'hF, 32'd0, 1'b0, -1, 1'b1, "wr_cmp_hi1");
    w = last_acc;
    repeat (3) @(negedge clk);
    check("irq_at_cmp_write",   32'(irq1_log[w & 255]), 32'd1);
    check("irq_after_cmp_write", 32'(irq1_log[(w + 1) & 255]), 32'd0);

    // Response stall: data and handshake hold while rsp_ready is low.
    @(posedge clk); #1 rsp_ready = 1'b0;
    bus_req(1'b0, TIMER_MTIMECMP_LO_ADDR, '0, '0, 32'd5, 1'b0, -1, 1'b0, "stall_rd");
    for (int i = 0; i < 5; i++) begin
      check("stall_rsp_valid", 32'(m_rsp_valid), 32'd1);
      check("stall_rsp_rdata", m_rsp_rdata, 32'd5);
      check("stall_req_ready", 32'(m_req_ready), 32'd0);
      @(negedge clk);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("stall_drained", 32'(sb_q.size()), 32'd0);
    bus_req(1'b0, 5'h0B, '0, '0, 32'd5, 1'b0, -1, 1'b1, "rd_low_bits_ignored");

    // 64-bit wrap: high half reads 0 once the counter rolls over.
    bus_req(1'b1, TIMER_MTIME_HI_ADDR, 32'hFFFF_FFFF, 4'hF, 32'd0, 1'b0, -1, 1'b1, "wr_hi_ones");
    bus_req(1'b1, TIMER_MTIME_LO_ADDR, 32'hFFFF_FFFF, 4'hF, 32'd0, 1'b0, -1, 1'b1, "wr_lo_ones");
    b = last_acc;
    bus_req(1'b0, TIMER_MTIME_HI_ADDR, '0, '0, 32'd0, 1'b0, -1, 1'b1, "wrap_hi");
    bus_req(1'b0, TIMER_MTIME_LO_ADDR, '0, '0, 32'hFFFF_FFFE, 1'b0, b, 1'b1, "wrap_lo");

    // Byte-1 write coincident with a tick: only byte 1 changes, no increment.
    bus_req(1'b1, TIMER_MTIME_LO_ADDR, 32'd0, 4'hF, 32'd0, 1'b0, -1, 1'b1, "wr_lo_zero");
    a0 = last_acc;
    bus_req(1'b1, TIMER_MTIME_LO_ADDR, 32'h0000_AB00, 4'b0010, 32'd0, 1'b0, -1, 1'b1, "wr_byte1");
    bus_req(1'b0, TIMER_MTIME_LO_ADDR, '0, '0, 32'h0000_AAFE, 1'b0, a0, 1'b1, "rd_byte1");

    // Unmapped addresses.
    bus_req(1'b0, 5'h14, '0, '0, 32'd0, 1'b1, -1, 1'b1, "rd_illegal_14");
    bus_req(1'b1, 5'h18, 32'hFFFF_FFFF, 4'hF, 32'd0, 1'b1, -1, 1'b1, "wr_illegal_18");
    bus_req(1'b0, TIMER_MTIMECMP_HI_ADDR, '0, '0, 32'd1, 1'b0, -1, 1'b1, "cmp_hi_intact");

    // Software interrupt register.
    bus_req(1'b1, TIMER_MSIP_ADDR, 32'd1, 4'hF, 32'd0, msip_ill, -1, 1'b1, "wr_msip");
    check("swirq", 32'(swirq1), msip_exp);
    bus_req(1'b0, TIMER_MSIP_ADDR, '0, '0, msip_exp, msip_ill, -1, 1'b1, "rd_msip");

    // Reset with a response pending abandons it.
    @(posedge clk); #1 rsp_ready = 1'b0;
    bus_req(1'b0, TIMER_MTIMECMP_HI_ADDR, '0, '0, 32'd1, 1'b0, -1, 1'b0, "abandoned");
    rst = 1'b1;
    @(negedge clk);
    check("midrst_rsp_valid", 32'(m_rsp_valid), 32'd0);
    check("midrst_req_ready", 32'(m_req_ready), 32'd1);
    check("midrst_swirq", 32'(swirq1), 32'd0);
    sb_q.delete();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("postrst_no_rsp", 32'(m_rsp_valid), 32'd0);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    bus_req(1'b0, TIMER_MTIMECMP_HI_ADDR, '0, '0, 32'hFFFF_FFFF, 1'b0, -1, 1'b1, "postrst_cmp_hi");
    bus_req(1'b0, TIMER_MTIME_HI_ADDR, '0, '0, 32'd0, 1'b0, -1, 1'b1, "postrst_mtime_hi");
    check("postrst_irq", 32'(irq1), 32'd0);

    repeat (2) @(negedge clk);
    if (sb_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL leftover_expectations: got %0d pending, expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
